// File: rtl/draw_layer_stack_if.sv
// Configuration write channel for draw_layer_stack: one layer's
// rectangle, colour and enable per accepted valid/ready transfer.
interface draw_layer_stack_if #(
    parameter int N_LAYERS = 4,
    parameter int COORD_W  = 11,
    parameter int COLOR_W  = 12
);
    localparam int LAYER_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [LAYER_W-1:0] cfg_layer;
    logic               cfg_en;
    logic [COORD_W-1:0] cfg_xpos;
    logic [COORD_W-1:0] cfg_ypos;
    logic [COORD_W-1:0] cfg_width;
    logic [COORD_W-1:0] cfg_height;
    logic [COLOR_W-1:0] cfg_color;

    modport master (
        output cfg_valid, cfg_layer, cfg_en, cfg_xpos, cfg_ypos,
               cfg_width, cfg_height, cfg_color,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_layer, cfg_en, cfg_xpos, cfg_ypos,
               cfg_width, cfg_height, cfg_color,
        output cfg_ready
    );
endinterface

// File: rtl/draw_layer_stack.sv
// Overlay compositor: paints N_LAYERS solid rectangles over the incoming pixel
// with a 2-stage pipeline; layer config is double-buffered and committed at vblank entry.
module draw_layer_stack #(
    parameter int N_LAYERS = 4,
    parameter int COORD_W  = 11,
    parameter int COLOR_W  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] in_hcount,
    input  logic [COORD_W-1:0] in_vcount,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic               in_hblnk,
    input  logic               in_vblnk,
    input  logic [COLOR_W-1:0] in_rgb,
    output logic [COORD_W-1:0] out_hcount,
    output logic [COORD_W-1:0] out_vcount,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic               out_hblnk,
    output logic               out_vblnk,
    output logic [COLOR_W-1:0] out_rgb,
    draw_layer_stack_if.slave  cfg,
    output logic               commit_pulse
);
    localparam int LAYER_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    logic vblnk_prev_reg;
    logic ready_reg;
    logic commit;
    logic cfg_take;

    // Commit on the rising edge of vblank; writes stall for that one cycle so
    // the shadow copy and a new write never collide.
    assign commit       = in_vblnk & ~vblnk_prev_reg & ~rst;
    assign commit_pulse = commit;
    assign cfg.cfg_ready = ready_reg & ~commit;
    assign cfg_take     = cfg.cfg_valid & cfg.cfg_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_reg <= 1'b0;
            ready_reg      <= 1'b0;
        end else begin
            vblnk_prev_reg <= in_vblnk;
            ready_reg      <= 1'b1;
        end
    end

    logic [N_LAYERS-1:0]               hit_next;
    logic [N_LAYERS-1:0]               hit_reg;
    logic [N_LAYERS-1:0][COLOR_W-1:0]  act_color;

    genvar gi;
    generate
        for (gi = 0; gi < N_LAYERS; gi++) begin : g_layer
            logic               sh_en_reg,  act_en_reg;
            logic [COORD_W-1:0] sh_x_reg,   act_x_reg;
            logic [COORD_W-1:0] sh_y_reg,   act_y_reg;
            logic [COORD_W-1:0] sh_w_reg,   act_w_reg;
            logic [COORD_W-1:0] sh_h_reg,   act_h_reg;
            logic [COLOR_W-1:0] sh_col_reg, act_col_reg;
            logic [COORD_W:0]   x_end;
            logic [COORD_W:0]   y_end;

            // Writes to a layer index outside the stack match no gi and are dropped.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sh_en_reg   <= 1'b0;
                    sh_x_reg    <= '0;
                    sh_y_reg    <= '0;
                    sh_w_reg    <= '0;
                    sh_h_reg    <= '0;
                    sh_col_reg  <= '0;
                    act_en_reg  <= 1'b0;
                    act_x_reg   <= '0;
                    act_y_reg   <= '0;
                    act_w_reg   <= '0;
                    act_h_reg   <= '0;
                    act_col_reg <= '0;
                end else begin
                    if (cfg_take && (cfg.cfg_layer == LAYER_W'(gi))) begin
                        sh_en_reg  <= cfg.cfg_en;
                        sh_x_reg   <= cfg.cfg_xpos;
                        sh_y_reg   <= cfg.cfg_ypos;
                        sh_w_reg   <= cfg.cfg_width;
                        sh_h_reg   <= cfg.cfg_height;
                        sh_col_reg <= cfg.cfg_color;
                    end
                    if (commit) begin
                        act_en_reg  <= sh_en_reg;
                        act_x_reg   <= sh_x_reg;
                        act_y_reg   <= sh_y_reg;
                        act_w_reg   <= sh_w_reg;
                        act_h_reg   <= sh_h_reg;
                        act_col_reg <= sh_col_reg;
                    end
                end
            end

            // One extra bit on the far edges clips layers at the frame edge
            // instead of wrapping; zero width/height can never satisfy both bounds.
            assign x_end = {1'b0, act_x_reg} + {1'b0, act_w_reg};
            assign y_end = {1'b0, act_y_reg} + {1'b0, act_h_reg};

            assign hit_next[gi] = act_en_reg
                                & (in_hcount >= act_x_reg) & ({1'b0, in_hcount} < x_end)
                                & (in_vcount >= act_y_reg) & ({1'b0, in_vcount} < y_end);

            assign act_color[gi] = act_col_reg;
        end
    endgenerate

    logic [COORD_W-1:0] s1_hcount_reg;
    logic [COORD_W-1:0] s1_vcount_reg;
    logic               s1_hsync_reg;
    logic               s1_vsync_reg;
    logic               s1_hblnk_reg;
    logic               s1_vblnk_reg;
    logic [COLOR_W-1:0] s1_rgb_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_reg       <= '0;
            s1_hcount_reg <= '0;
            s1_vcount_reg <= '0;
            s1_hsync_reg  <= 1'b0;
            s1_vsync_reg  <= 1'b0;
            s1_hblnk_reg  <= 1'b0;
            s1_vblnk_reg  <= 1'b0;
            s1_rgb_reg    <= '0;
        end else begin
            hit_reg       <= hit_next;
            s1_hcount_reg <= in_hcount;
            s1_vcount_reg <= in_vcount;
            s1_hsync_reg  <= in_hsync;
            s1_vsync_reg  <= in_vsync;
            s1_hblnk_reg  <= in_hblnk;
            s1_vblnk_reg  <= in_vblnk;
            s1_rgb_reg    <= in_rgb;
        end
    end

    // Colours are read from the active set here; they only change at vblank
    // entry, when the pixel in flight is blanked anyway.
    logic [COLOR_W-1:0] rgb_next;

    always_comb begin
        rgb_next = s1_rgb_reg;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (hit_reg[i]) begin
                rgb_next = act_color[i];
            end
        end
        if (s1_hblnk_reg || s1_vblnk_reg) begin
            rgb_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_hcount <= '0;
            out_vcount <= '0;
            out_hsync  <= 1'b0;
            out_vsync  <= 1'b0;
            out_hblnk  <= 1'b0;
            out_vblnk  <= 1'b0;
            out_rgb    <= '0;
        end else begin
            out_hcount <= s1_hcount_reg;
            out_vcount <= s1_vcount_reg;
            out_hsync  <= s1_hsync_reg;
            out_vsync  <= s1_vsync_reg;
            out_hblnk  <= s1_hblnk_reg;
            out_vblnk  <= s1_vblnk_reg;
            out_rgb    <= rgb_next;
        end
    end
endmodule
